deserializer: RTL and testbench

Serial-to-parallel receive stage that consumes the single-bit stream produced by `serializer` and rebuilds WIDTH-bit words. It finds word boundaries by hunting for a comma pattern, then emits one word every WIDTH clocks with a valid strobe. It sits directly downstream of `serializer`, in the same clock domain, and feeds the word-level decoder.

---
 rtl/deserializer.sv | 128 ++++++++++++
 tb/tb_deserializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// deserializer: rebuilds WIDTH-bit words from an LSB-first serial stream,
//   aligning on a comma pattern and strobing one word every WIDTH clocks.
// Latency: a word's last bit is sampled at edge k; O/valid update at edge k+1.
// Backpressure: none; the consumer must take every valid strobe.
//
// Ports:
//   clk    - clock, all inputs sampled on the rising edge
//   reset  - asynchronous, active-high reset
//   I      - serial data, one bit per clock, LSB of each word first
//   O      - recovered word, held between strobes
//   valid  - one-cycle strobe, O holds a new word
//   locked - word alignment established
//
// Optional feature macro: DESERIALIZER_COMMA_STRIP_EN
//   When defined, comma words refresh O but never raise valid (both the
//   locking comma and boundary commas). Alignment and lock tracking are
//   unchanged.

module deserializer #(
    parameter int              WIDTH      = 10,
    parameter logic [WIDTH-1:0] COMMA     = 10'b0011111010,
    parameter int              MISS_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             I,
    output logic [WIDTH-1:0] O,
    output logic             valid,
    output logic             locked
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_miss;

    logic             w_match;
    logic             w_boundary;
    logic [3:0]       w_miss_next;
    logic             w_miss_hit;
    logic             w_strobe_ok;

    // Comparison is on the registered window, so a word completed at edge k
    // is acted on at edge k+1.
    assign w_match     = (r_sreg == COMMA);
    assign w_boundary  = (r_cnt == CW'(WIDTH - 1));
    assign w_miss_next = r_miss + 4'd1;
    assign w_miss_hit  = (w_miss_next == 4'(MISS_LIMIT));

`ifdef DESERIALIZER_COMMA_STRIP_EN
    // Comma words are alignment filler; hide them from the consumer.
    assign w_strobe_ok = ~w_match;
`else
    assign w_strobe_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HUNT;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_miss  <= '0;
            O       <= '0;
            valid   <= 1'b0;
            locked  <= 1'b0;
        end else begin
            // Newest bit enters at the MSB so an LSB-first word lands in order.
            r_sreg <= {I, r_sreg[WIDTH-1:1]};

            case (r_state)
                ST_HUNT: begin
                    r_cnt <= '0;
                    if (w_match) begin
                        O       <= r_sreg;
                        valid   <= w_strobe_ok;
                        r_miss  <= '0;
                        r_state <= ST_LOCKED;
                        locked  <= 1'b1;
                    end else begin
                        valid <= 1'b0;
                    end
                end

                ST_LOCKED: begin
                    if (w_boundary) begin
                        r_cnt <= '0;
                        O     <= r_sreg;
                        valid <= w_strobe_ok;
                        // Non-comma boundary words leave the miss count alone.
                        if (w_match) begin
                            r_miss <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        valid <= 1'b0;
                        if (w_match) begin
                            if (w_miss_hit) begin
                                // Drop lock; this comma is not reused for
                                // relock, the next sighting in HUNT is.
                                r_state <= ST_HUNT;
                                locked  <= 1'b0;
                                r_miss  <= '0;
                                r_cnt   <= '0;
                            end else begin
                                r_miss <= w_miss_next;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= ST_HUNT;
                    r_cnt   <= '0;
                    valid   <= 1'b0;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed bench for deserializer with a bit-history model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Model tracks lock by elapsed edges since the locking comma.

module tb_deserializer;

    localparam int        W  = 10;
    localparam logic [9:0] C  = 10'b0011111010;
    localparam logic [9:0] W1 = 10'b0010101011;
    localparam logic [9:0] W2 = 10'b1100110011;
    localparam logic [9:0] WX = 10'b1010110011;
    localparam int        MISS_LIMIT = 3;
`ifdef DESERIALIZER_COMMA_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       I     = 1'b0;
    logic [9:0] O;
    logic       valid;
    logic       locked;

    deserializer #(.WIDTH(W), .COMMA(C), .MISS_LIMIT(MISS_LIMIT)) dut (
        .clk    (clk),
        .reset  (reset),
        .I      (I),
        .O      (O),
        .valid  (valid),
        .locked (locked)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit         mh[$];          // last W received bits, oldest first
    logic [9:0] m_O      = '0;
    logic       m_valid  = 1'b0;
    logic       m_locked = 1'b0;
    int         m_since  = 0;   // edges elapsed since the locking comma
    int         m_miss   = 0;

    always @(posedge clk or posedge reset) begin : model
        logic [W-1:0] win;
        bit           hit;
        if (reset) begin
            mh = {};
            for (int i = 0; i < W; i++) mh.push_back(1'b0);
            m_O      = '0;
            m_valid  = 1'b0;
            m_locked = 1'b0;
            m_since  = 0;
            m_miss   = 0;
        end else begin
            for (int i = 0; i < W; i++) win[i] = mh[i];
            hit = (win == C);
            if (!m_locked) begin
                if (hit) begin
                    m_O      = win;
                    m_valid  = !STRIP;
                    m_locked = 1'b1;
                    m_since  = 0;
                    m_miss   = 0;
                end else begin
                    m_valid = 1'b0;
                end
            end else begin
                m_since = m_since + 1;
                if (m_since % W == 0) begin
                    m_O     = win;
                    m_valid = !(STRIP && hit);
                    if (hit) m_miss = 0;
                end else begin
                    m_valid = 1'b0;
                    if (hit) begin
                        m_miss = m_miss + 1;
                        if (m_miss == MISS_LIMIT) begin
                            m_locked = 1'b0;
                            m_miss   = 0;
                        end
                    end
                end
            end
            mh.push_back(I);
            void'(mh.pop_front());
        end
    end

    // ---------------- checking ----------------
    int         n_vec   = 0;
    int         n_err   = 0;
    int         cyc     = 0;
    logic       prev_lk = 1'b0;
    int         v_cyc[$];
    logic [9:0] v_dat[$];
    int         lr[$];
    int         lf[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_cycle();
        cyc++;
        n_vec++;
        if (O !== m_O || valid !== m_valid || locked !== m_locked) begin
            n_err++;
            $display("FAIL cycle %0d outputs: got O=%b valid=%b locked=%b, expected O=%b valid=%b locked=%b",
                     cyc, O, valid, locked, m_O, m_valid, m_locked);
        end
        if (valid === 1'b1) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(O);
        end
        if (locked === 1'b1 && !prev_lk) lr.push_back(cyc);
        if (locked !== 1'b1 && prev_lk)  lf.push_back(cyc);
        prev_lk = (locked === 1'b1);
    endtask

    task automatic tick(input logic b);
        @(negedge clk);
        compare_cycle();
        I = b;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < W; i++) tick(w[i]);
    endtask

    logic [9:0] e_dat[$];
    int         e_off[$];
    int         p_lock;

    initial begin
        // Reset held for three clocks with random data.
        for (int i = 0; i < 3; i++) begin
            tick(1'($urandom_range(0, 1)));
            if (i == 0) begin
                check("reset O", 32'(O), 32'd0);
                check("reset valid", 32'(valid), 32'd0);
                check("reset locked", 32'(locked), 32'd0);
            end
        end
        tick(1'b0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick(1'b0);
        check("idle strobes", 32'(v_dat.size()), 32'd0);
        check("idle lock", 32'(lr.size()), 32'd0);

        // Lock, continuous stream, slip and relock.
        p_lock = v_dat.size();
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)));
        send_word(C);
        send_word(W1);
        send_word(W2);
        for (int k = 0; k < 20; k++) send_word((k % 2 == 1) ? 10'h3FF : 10'h000);
        tick(1'b0);                       // slip by one bit
        for (int k = 0; k < 4; k++) send_word(C);
        for (int i = 0; i < 6; i++) tick(WX[i]);

        // Strobe value/offset table relative to the first lock rise.
        if (!STRIP) begin e_dat.push_back(C); e_off.push_back(0); end
        e_dat.push_back(W1); e_off.push_back(10);
        e_dat.push_back(W2); e_off.push_back(20);
        for (int k = 0; k < 20; k++) begin
            e_dat.push_back((k % 2 == 1) ? 10'h3FF : 10'h000);
            e_off.push_back(30 + 10 * k);
        end
        for (int g = 0; g < 3; g++) begin
            e_dat.push_back(10'h1F4);     // extra bit followed by comma bits 0..8
            e_off.push_back(230 + 10 * g);
        end
        if (!STRIP) begin e_dat.push_back(C); e_off.push_back(261); end

        check("lock rises", 32'(lr.size()), 32'd2);
        check("lock falls", 32'(lf.size()), 32'd1);
        check("strobe count", 32'(v_dat.size() - p_lock), 32'(e_dat.size()));
        if (lr.size() == 2 && lf.size() == 1) begin
            check("unlock offset", 32'(lf[0] - lr[0]), 32'd251);
            check("relock offset", 32'(lr[1] - lr[0]), 32'd261);
        end
        if (lr.size() > 0) begin
            for (int k = 0; k < e_dat.size(); k++) begin
                if (p_lock + k < v_dat.size()) begin
                    check($sformatf("strobe %0d value", k), 32'(v_dat[p_lock + k]), 32'(e_dat[k]));
                    check($sformatf("strobe %0d offset", k), 32'(v_cyc[p_lock + k] - lr[0]), 32'(e_off[k]));
                end
            end
        end

        // Reset while locked, counter at 5.
        @(posedge clk);
        #1;
        check("pre-reset locked", 32'(locked), 32'd1);
        check("pre-reset O", 32'(O), 32'(C));
        #1 reset = 1'b1;
        #1;
        check("async reset O", 32'(O), 32'd0);
        check("async reset valid", 32'(valid), 32'd0);
        check("async reset locked", 32'(locked), 32'd0);
        tick(1'b1);
        tick(1'b0);
        reset = 1'b0;
        send_word(WX);
        send_word(WX);
        check("no relock without comma", 32'(lr.size()), 32'd2);
        send_word(C);
        send_word(W1);
        tick(1'b0);
        tick(1'b0);
        check("relock after reset", 32'(lr.size()), 32'd3);
        if (lr.size() == 3 && v_dat.size() > 0) begin
            check("post-reset word", 32'(v_dat[v_dat.size() - 1]), 32'(W1));
            check("post-reset offset", 32'(v_cyc[v_cyc.size() - 1] - lr[2]), 32'd10);
        end
        tick(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
